md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Sequences the shared HI/LO multiply/divide resource of the pipelined MIPS core.
- Accepts E-stage md operations using the control decoder's 3-bit md opcode (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi/mflo, 0 none).
- Models multi-cycle latency, holds HI/LO, and raises the D-stage stall for md instructions that arrive while the unit is occupied.
- Honours exception flush at issue.

Parameters:
- MUL_CYC, 5, cycles from mult/multu issue to HI/LO update (>=1).
- DIV_CYC, 10, cycles from div/divu issue to HI/LO update (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_op_e  in  3  md opcode of instruction in E stage.
- a_e  in  32  forwarded rs value in E.
- b_e  in  32  forwarded rt value in E.
- flush  in  1  exception/eret flush; the E instruction must not take effect.
- md_in_d  in  1  D-stage instruction is any md op (md opcode != 0).
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- busy  out  1  multiply/divide in progress.
- stall  out  1  D-stage stall request.

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, state=IDLE, cnt=0, pending registers=0.
- start = valid mult/multu/div/divu op on md_op_e & !flush & state==IDLE.
- States:
  - IDLE: on start, capture the full 64-bit result into pend_hi/pend_lo.
    - mult/multu: go to MUL with cnt=MUL_CYC-1.
    - div/divu: go to DIV with cnt=DIV_CYC-1.
  - MUL/DIV: cnt decrements every cycle. When cnt==0, hi<=pend_hi, lo<=pend_lo, return to IDLE. busy=1 throughout.
- Latency: HI/LO are visible N clock edges after the issue edge, where N=MUL_CYC or DIV_CYC. busy is high for exactly N cycles after the issue edge.
- Arithmetic:
  - mult: signed 32x32 to 64, hi=[63:32], lo=[31:0].
  - multu: same, unsigned.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divide by zero (b_e==0): hi=a_e, lo=32'hFFFF_FFFF, normal DIV_CYC latency.
  - div of 0x80000000 by -1: lo=0x80000000, hi=0.
- mthi/mtlo in IDLE & !flush: hi<=a_e or lo<=a_e at the next edge, no busy.
- mfhi/mflo (op 7): no state change. The read path uses hi/lo directly.
- stall = md_in_d & (busy | start). This makes an md op in D wait for completion, including mfhi/mflo.
- An md op presented on md_op_e while busy is a contract violation and is ignored (no state change). The stall guarantees it cannot occur.
- flush with an md op in E: that op is discarded (no start, no mthi/mtlo write). flush while busy does not cancel the in-flight operation, which commits normally.
- A completion edge and an mthi/mtlo in E on the same cycle cannot coincide, because the mthi/mtlo would be stalled. If one is forced, completion wins.
- Ops 0 and 7 never affect state.

Test Plan:
- mult a=6 b=7 -> busy high 5 cycles. hi=0, lo=42 exactly 5 edges after issue. hi/lo unchanged (0) before then.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. mult a=0xFFFFFFFF b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9) b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=0 -> hi=7, lo=0xFFFFFFFF.
- Stall: issue div, hold md_in_d=1 -> stall=1 on the issue cycle and for all 10 busy cycles, 0 on the cycle after completion. md_in_d=0 -> stall=0 throughout.
- Flush: mult with flush=1 -> busy stays 0, hi/lo unchanged. mthi a=0x1234 with flush=1 -> hi unchanged. Flush asserted mid-div -> div still commits.
- Async reset: assert reset=0 mid-mult (cycle 3) without a clock edge -> busy=0, hi=lo=0 immediately. After release, mtlo a=0xABCD -> lo=0xABCD next edge.

Source files
------------

// File: rtl/md_sequencer_if.sv
// Bundle of the E/D-stage multiply/divide signals between the core and md_sequencer.
interface md_sequencer_if;
    logic [2:0]  md_op_e;
    logic [31:0] a_e;
    logic [31:0] b_e;
    logic        flush;
    logic        md_in_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    // Pipeline side: presents operations, observes HI/LO and the stall.
    modport master (
        output md_op_e, a_e, b_e, flush, md_in_d,
        input  hi, lo, busy, stall
    );

    // Sequencer side.
    modport slave (
        input  md_op_e, a_e, b_e, flush, md_in_d,
        output hi, lo, busy, stall
    );
endinterface

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer for the pipelined MIPS core.
// The arithmetic result is captured at issue and released into HI/LO after a
// fixed latency, so the unit looks like a multi-cycle multiplier/divider to
// the rest of the pipeline.
module md_sequencer #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave md
);

    localparam int MAX_CYC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYC - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // Full 64-bit product; operands are extended to 64 bits first so the
    // truncated product is exact for both signed and unsigned forms.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] p;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return p;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, rem 0.
    // Divide by zero yields HI=dividend, LO=all ones.
    function automatic logic [63:0] div64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               neg_a;
        logic               neg_b;
        logic [31:0]        ma;
        logic [31:0]        mb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa    = a;
        sb    = b;
        neg_a = sgn && (sa < 0);
        neg_b = sgn && (sb < 0);
        ma    = neg_a ? (32'd0 - a) : a;
        mb    = neg_b ? (32'd0 - b) : b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = ma / mb;
            r = ma % mb;
            if (neg_a != neg_b) q = 32'd0 - q;
            if (neg_a)          r = 32'd0 - r;
        end
        return {r, q};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;

    logic             is_mul;
    logic             is_div;
    logic             start;
    logic             busy;
    logic [63:0]      mul_res;
    logic [63:0]      div_res;

    assign is_mul  = (md.md_op_e == OP_MULT) || (md.md_op_e == OP_MULTU);
    assign is_div  = (md.md_op_e == OP_DIV)  || (md.md_op_e == OP_DIVU);
    assign start   = (is_mul || is_div) && !md.flush && (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign mul_res = mul64(md.a_e, md.b_e, md.md_op_e == OP_MULT);
    assign div_res = div64(md.a_e, md.b_e, md.md_op_e == OP_DIV);

    // Next-state: issue captures the result, the countdown releases it; moves
    // to HI/LO only happen while idle, so completion always takes priority.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        {pend_hi_d, pend_lo_d} = mul_res;
                        state_d                = MUL;
                        cnt_d                  = MUL_LOAD;
                    end else begin
                        {pend_hi_d, pend_lo_d} = div_res;
                        state_d                = DIV;
                        cnt_d                  = DIV_LOAD;
                    end
                end else if (!md.flush && (md.md_op_e == OP_MTHI)) begin
                    hi_d = md.a_e;
                end else if (!md.flush && (md.md_op_e == OP_MTLO)) begin
                    lo_d = md.a_e;
                end
            end
            MUL, DIV: begin
                if (cnt_q == '0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and architectural registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
    assign md.busy  = busy;
    // Any md op in D waits while the unit is occupied or being started.
    assign md.stall = md.md_in_d && (busy || start);

endmodule

// File: tb/tb_md_sequencer.sv
// Directed-vector bench for md_sequencer (MUL_CYC=5, DIV_CYC=10).
module tb_md_sequencer;

    logic clk;
    logic reset;
    int   vec;
    int   miss;

    md_sequencer_if mdif ();

    md_sequencer #(
        .MUL_CYC(5),
        .DIV_CYC(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (mdif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        mdif.md_op_e = 3'd0;
        mdif.a_e     = 32'd0;
        mdif.b_e     = 32'd0;
        mdif.flush   = 1'b0;
        mdif.md_in_d = 1'b0;
        #2;
        vec++; if (mdif.hi !== 32'd0) begin miss++; $display("FAIL reset_hi: got %h want 0", mdif.hi); end
        vec++; if (mdif.lo !== 32'd0) begin miss++; $display("FAIL reset_lo: got %h want 0", mdif.lo); end
        vec++; if (mdif.busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b want 0", mdif.busy); end
        vec++; if (mdif.stall !== 1'b0) begin miss++; $display("FAIL reset_stall: got %b want 0", mdif.stall); end
        #10;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult_latency();
        mdif.md_op_e = 3'd1; mdif.a_e = 32'd6; mdif.b_e = 32'd7;
        tick();
        mdif.md_op_e = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            vec++; if (mdif.busy !== 1'b1) begin miss++; $display("FAIL mult_busy c%0d: got %b want 1", i, mdif.busy); end
            vec++; if (mdif.lo !== 32'd0) begin miss++; $display("FAIL mult_lo_early c%0d: got %h want 0", i, mdif.lo); end
            tick();
        end
        vec++; if (mdif.busy !== 1'b0) begin miss++; $display("FAIL mult_busy_end: got %b want 0", mdif.busy); end
        vec++; if (mdif.hi !== 32'd0) begin miss++; $display("FAIL mult_hi: got %h want 0", mdif.hi); end
        vec++; if (mdif.lo !== 32'd42) begin miss++; $display("FAIL mult_lo: got %h want 2a", mdif.lo); end
    endtask

    task automatic test_arith();
        logic [2:0]  ops [7] = '{3'd2, 3'd1, 3'd3, 3'd3, 3'd4, 3'd3, 3'd3};
        logic [31:0] as  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7,
                                 32'd7, 32'h8000_0000, 32'hFFFF_FFFB};
        logic [31:0] bs  [7] = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFE,
                                 32'd0, 32'hFFFF_FFFF, 32'd0};
        int          cyc [7] = '{5, 5, 10, 10, 10, 10, 10};
        logic [31:0] ehi [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
                                 32'd7, 32'd0, 32'hFFFF_FFFB};
        logic [31:0] elo [7] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int t = 0; t < 7; t++) begin
            mdif.md_op_e = ops[t]; mdif.a_e = as[t]; mdif.b_e = bs[t];
            tick();
            mdif.md_op_e = 3'd0;
            for (int i = 1; i <= cyc[t]; i++) begin
                vec++; if (mdif.busy !== 1'b1) begin miss++; $display("FAIL arith%0d_busy c%0d: got %b want 1", t, i, mdif.busy); end
                tick();
            end
            vec++; if (mdif.busy !== 1'b0) begin miss++; $display("FAIL arith%0d_done: got %b want 0", t, mdif.busy); end
            vec++; if (mdif.hi !== ehi[t]) begin miss++; $display("FAIL arith%0d_hi: got %h want %h", t, mdif.hi, ehi[t]); end
            vec++; if (mdif.lo !== elo[t]) begin miss++; $display("FAIL arith%0d_lo: got %h want %h", t, mdif.lo, elo[t]); end
        end
    endtask

    task automatic test_mthi_mtlo();
        mdif.md_op_e = 3'd5; mdif.a_e = 32'h1111_1111;
        #1;
        vec++; if (mdif.busy !== 1'b0) begin miss++; $display("FAIL mthi_busy: got %b want 0", mdif.busy); end
        tick();
        mdif.md_op_e = 3'd6; mdif.a_e = 32'h2222_2222;
        tick();
        mdif.md_op_e = 3'd7; mdif.a_e = 32'h3333_3333;
        tick();
        mdif.md_op_e = 3'd0;
        tick();
        vec++; if (mdif.hi !== 32'h1111_1111) begin miss++; $display("FAIL mthi_hi: got %h want 11111111", mdif.hi); end
        vec++; if (mdif.lo !== 32'h2222_2222) begin miss++; $display("FAIL mtlo_lo: got %h want 22222222", mdif.lo); end
        vec++; if (mdif.busy !== 1'b0) begin miss++; $display("FAIL mtx_busy: got %b want 0", mdif.busy); end
    endtask

    task automatic test_flush();
        mdif.md_op_e = 3'd1; mdif.a_e = 32'd3; mdif.b_e = 32'd3; mdif.flush = 1'b1;
        tick();
        mdif.md_op_e = 3'd5; mdif.a_e = 32'h1234;
        tick();
        mdif.md_op_e = 3'd0; mdif.flush = 1'b0;
        vec++; if (mdif.busy !== 1'b0) begin miss++; $display("FAIL flush_busy: got %b want 0", mdif.busy); end
        for (int i = 0; i < 5; i++) tick();
        vec++; if (mdif.hi !== 32'h1111_1111) begin miss++; $display("FAIL flush_hi: got %h want 11111111", mdif.hi); end
        vec++; if (mdif.lo !== 32'h2222_2222) begin miss++; $display("FAIL flush_lo: got %h want 22222222", mdif.lo); end
        // div 100/7 with a flush pulse in the middle of the countdown
        mdif.md_op_e = 3'd3; mdif.a_e = 32'd100; mdif.b_e = 32'd7;
        tick();
        mdif.md_op_e = 3'd0;
        for (int i = 1; i <= 10; i++) begin
            mdif.flush = (i == 3);
            tick();
        end
        mdif.flush = 1'b0;
        vec++; if (mdif.busy !== 1'b0) begin miss++; $display("FAIL flushdiv_busy: got %b want 0", mdif.busy); end
        vec++; if (mdif.lo !== 32'd14) begin miss++; $display("FAIL flushdiv_lo: got %h want e", mdif.lo); end
        vec++; if (mdif.hi !== 32'd2) begin miss++; $display("FAIL flushdiv_hi: got %h want 2", mdif.hi); end
    endtask

    task automatic test_stall();
        mdif.md_op_e = 3'd3; mdif.a_e = 32'd9; mdif.b_e = 32'd4; mdif.md_in_d = 1'b1;
        #1;
        vec++; if (mdif.stall !== 1'b1) begin miss++; $display("FAIL stall_issue: got %b want 1", mdif.stall); end
        tick();
        mdif.md_op_e = 3'd0;
        for (int i = 1; i <= 10; i++) begin
            vec++; if (mdif.stall !== 1'b1) begin miss++; $display("FAIL stall_busy c%0d: got %b want 1", i, mdif.stall); end
            tick();
        end
        vec++; if (mdif.stall !== 1'b0) begin miss++; $display("FAIL stall_after: got %b want 0", mdif.stall); end
        vec++; if (mdif.lo !== 32'd2) begin miss++; $display("FAIL stall_div_lo: got %h want 2", mdif.lo); end
        mdif.md_in_d = 1'b0; mdif.md_op_e = 3'd4; mdif.a_e = 32'd9; mdif.b_e = 32'd4;
        #1;
        vec++; if (mdif.stall !== 1'b0) begin miss++; $display("FAIL nostall_issue: got %b want 0", mdif.stall); end
        tick();
        mdif.md_op_e = 3'd0;
        for (int i = 1; i <= 10; i++) begin
            vec++; if (mdif.stall !== 1'b0) begin miss++; $display("FAIL nostall c%0d: got %b want 0", i, mdif.stall); end
            tick();
        end
        vec++; if (mdif.hi !== 32'd1) begin miss++; $display("FAIL nostall_hi: got %h want 1", mdif.hi); end
    endtask

    task automatic test_busy_ignore();
        mdif.md_op_e = 3'd2; mdif.a_e = 32'd3; mdif.b_e = 32'd4;
        tick();
        mdif.md_op_e = 3'd5; mdif.a_e = 32'hDEAD;
        tick();
        mdif.md_op_e = 3'd1; mdif.a_e = 32'd9; mdif.b_e = 32'd9;
        tick();
        mdif.md_op_e = 3'd0;
        tick();
        tick();
        tick();
        vec++; if (mdif.busy !== 1'b0) begin miss++; $display("FAIL ignore_busy: got %b want 0", mdif.busy); end
        vec++; if (mdif.hi !== 32'd0) begin miss++; $display("FAIL ignore_hi: got %h want 0", mdif.hi); end
        vec++; if (mdif.lo !== 32'd12) begin miss++; $display("FAIL ignore_lo: got %h want c", mdif.lo); end
    endtask

    task automatic test_async_reset();
        mdif.md_op_e = 3'd1; mdif.a_e = 32'd3; mdif.b_e = 32'd5;
        tick();
        mdif.md_op_e = 3'd0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        vec++; if (mdif.busy !== 1'b0) begin miss++; $display("FAIL areset_busy: got %b want 0", mdif.busy); end
        vec++; if (mdif.hi !== 32'd0) begin miss++; $display("FAIL areset_hi: got %h want 0", mdif.hi); end
        vec++; if (mdif.lo !== 32'd0) begin miss++; $display("FAIL areset_lo: got %h want 0", mdif.lo); end
        #3;
        reset = 1'b1;
        tick();
        mdif.md_op_e = 3'd6; mdif.a_e = 32'hABCD;
        tick();
        mdif.md_op_e = 3'd0;
        vec++; if (mdif.lo !== 32'hABCD) begin miss++; $display("FAIL areset_mtlo: got %h want abcd", mdif.lo); end
        for (int i = 0; i < 6; i++) tick();
        vec++; if (mdif.hi !== 32'd0) begin miss++; $display("FAIL areset_nocommit_hi: got %h want 0", mdif.hi); end
        vec++; if (mdif.lo !== 32'hABCD) begin miss++; $display("FAIL areset_nocommit_lo: got %h want abcd", mdif.lo); end
    endtask

    initial begin
        vec  = 0;
        miss = 0;
        test_reset();
        test_mult_latency();
        test_arith();
        test_mthi_mtlo();
        test_flush();
        test_stall();
        test_busy_ignore();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
